inv_mix_columns: RTL

INV_MIX_COLUMNS -- requirements
Module: inv_mix_columns

---
 rtl/inv_mix_columns.sv | 112 +++++++++++
 1 files changed

// File: rtl/inv_mix_columns.sv
// AES InvMixColumns over a 128-bit state, one column per cycle.
// A bypass flag passes the state through unchanged for the final decryption round.
//
// state | meaning
// IDLE  | ready for a new state
// COL   | transforming column cnt (0..3)
// DONE  | result held on s_o until out_ready
module inv_mix_columns (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] s_in,
  input  logic         bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] s_o,
  output logic         busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] COL  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]   state;
  logic [1:0]   cnt;
  logic [127:0] work;
  logic         byp;
  logic [31:0]  col_cur;
  logic [31:0]  col_new;
  logic [127:0] work_nxt;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] c);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  always_comb begin
    col_cur  = '0;
    work_nxt = work;
    for (int c = 0; c < 4; c++)
      if (cnt == 2'(c)) col_cur = work[127-32*c -: 32];
    col_new = byp ? col_cur : inv_col(col_cur);
    for (int c = 0; c < 4; c++)
      if (cnt == 2'(c)) work_nxt[127-32*c -: 32] = col_new;
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      work      <= '0;
      byp       <= 1'b0;
      s_o       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= s_in;
            byp   <= bypass;
            cnt   <= '0;
            state <= COL;
          end
        end
        COL: begin
          work <= work_nxt;
          cnt  <= cnt + 2'd1;
          // load s_o from the merged value so the last column is included
          if (cnt == 2'd3) begin
            s_o       <= work_nxt;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
